// File: rtl/ddr2_ctrl_output.sv
// rtl/ddr2_ctrl_output.sv - DDR2 read-return packer: size FIFO, 32->128 line packing, credit-gated line buffer
// Optional statistics counters are enabled by defining DDR2_OUT_STAT_EN.
module ddr2_ctrl_output #(
  parameter int SIZE_FIFO_DEPTH = 8,
  parameter int OBUF_DEPTH      = 64,
  parameter int MAX_REQ_LINES   = 32
) (
  input  logic         ddr2_clk,
  input  logic         sys_rst_n,
  input  logic [6:0]   rd_ddr2_size,
  input  logic         rd_ddr2_size_wrreq,
  output logic         read_permit,
  input  logic [31:0]  local_rdata,
  input  logic         local_rdata_valid,
  output logic [127:0] ddr2um_data,
  output logic         ddr2um_last,
  output logic         ddr2um_valid,
  input  logic         ddr2um_rdreq,
  output logic         rd_err
`ifdef DDR2_OUT_STAT_EN
  ,
  input  logic         stat_clr,
  output logic [31:0]  stat_req_cnt,
  output logic [31:0]  stat_line_cnt
`endif
);

  localparam int SAW = $clog2(SIZE_FIFO_DEPTH);
  localparam int OAW = $clog2(OBUF_DEPTH);
  localparam logic [SAW:0] SF_FULL       = (SAW+1)'(SIZE_FIFO_DEPTH);
  localparam logic [SAW:0] SF_PERMIT_MAX = (SAW+1)'(SIZE_FIFO_DEPTH - 2);
  localparam logic [OAW:0] OB_FULL       = (OAW+1)'(OBUF_DEPTH);
  localparam logic [6:0]   CREDIT_MAX    = 7'(OBUF_DEPTH);
  localparam logic [6:0]   CREDIT_PERMIT = 7'(MAX_REQ_LINES);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
  state_t state, state_next;

  logic [6:0]     size_mem [SIZE_FIFO_DEPTH];
  logic [SAW-1:0] sf_rd, sf_wr;
  logic [SAW:0]   sf_cnt, sf_cnt_next;
  logic           sf_push, sf_pop;
  logic [6:0]     next_head;

  logic [6:0]     word_cnt, word_cnt_next;
  logic [1:0]     lane;
  logic [127:0]   pack, line_data;
  logic           beat, zero_pop, last_beat, line_push;

  logic [128:0]   ob_mem [OBUF_DEPTH];
  logic [OAW-1:0] ob_rd, ob_wr;
  logic [OAW:0]   ob_cnt;
  logic           ob_pop;

  logic [6:0]     credit, credit_next;
  logic [5:0]     req_lines;

  assign sf_push     = rd_ddr2_size_wrreq && (sf_cnt != SF_FULL);
  assign sf_pop      = zero_pop || last_beat;
  assign sf_cnt_next = sf_cnt + {{SAW{1'b0}}, sf_push} - {{SAW{1'b0}}, sf_pop};
  // Head after a pop: the second entry, or the size being pushed this very cycle.
  assign next_head   = (sf_cnt > (SAW+1)'(1)) ? size_mem[sf_rd + SAW'(1)] : rd_ddr2_size;

  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sf_cnt_next != '0) state_next = COLLECT;
      COLLECT: if (sf_cnt_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A size-0 head spends one cycle being popped; no beat is accepted in that cycle.
  always_comb begin
    beat      = 1'b0;
    zero_pop  = 1'b0;
    last_beat = 1'b0;
    if (state == COLLECT) begin
      zero_pop  = (word_cnt == '0);
      beat      = local_rdata_valid && (word_cnt != '0);
      last_beat = beat && (word_cnt == 7'd1);
    end
  end

  always_comb begin
    word_cnt_next = word_cnt;
    if (sf_pop)                        word_cnt_next = (sf_cnt_next == '0) ? 7'd0 : next_head;
    else if (beat)                     word_cnt_next = word_cnt - 7'd1;
    else if (state == IDLE && sf_push) word_cnt_next = rd_ddr2_size;
  end

  always_comb begin
    line_data = pack;
    case (lane)
      2'd0:    line_data[127:96] = local_rdata;
      2'd1:    line_data[95:64]  = local_rdata;
      2'd2:    line_data[63:32]  = local_rdata;
      default: line_data[31:0]   = local_rdata;
    endcase
  end

  assign line_push    = beat && (lane == 2'd3 || word_cnt == 7'd1);
  assign ddr2um_valid = (ob_cnt != '0);
  assign ob_pop       = ddr2um_rdreq && ddr2um_valid;
  assign ddr2um_data  = ddr2um_valid ? ob_mem[ob_rd][128:1] : '0;
  assign ddr2um_last  = ddr2um_valid ? ob_mem[ob_rd][0] : 1'b0;

  assign req_lines   = {1'b0, rd_ddr2_size[6:2]} + {5'd0, |rd_ddr2_size[1:0]};
  assign credit_next = credit - (sf_push ? {1'b0, req_lines} : 7'd0) + {6'd0, ob_pop};

  always_ff @(posedge ddr2_clk) begin
    if (sf_push)   size_mem[sf_wr] <= rd_ddr2_size;
    if (line_push) ob_mem[ob_wr]   <= {line_data, word_cnt == 7'd1};
  end

  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sf_rd       <= '0;
      sf_wr       <= '0;
      sf_cnt      <= '0;
      word_cnt    <= '0;
      lane        <= '0;
      pack        <= '0;
      ob_rd       <= '0;
      ob_wr       <= '0;
      ob_cnt      <= '0;
      credit      <= CREDIT_MAX;
      read_permit <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      if (sf_push) sf_wr <= sf_wr + SAW'(1);
      if (sf_pop)  sf_rd <= sf_rd + SAW'(1);
      sf_cnt   <= sf_cnt_next;
      word_cnt <= word_cnt_next;
      if (beat) begin
        lane <= last_beat ? 2'd0 : lane + 2'd1;
        pack <= line_push ? '0 : line_data;
      end
      if (line_push) ob_wr <= ob_wr + OAW'(1);
      if (ob_pop)    ob_rd <= ob_rd + OAW'(1);
      ob_cnt      <= ob_cnt + {{OAW{1'b0}}, line_push} - {{OAW{1'b0}}, ob_pop};
      credit      <= credit_next;
      read_permit <= (credit_next >= CREDIT_PERMIT) && (sf_cnt_next <= SF_PERMIT_MAX);
      if ((local_rdata_valid && state == IDLE) || (rd_ddr2_size_wrreq && sf_cnt == SF_FULL))
        rd_err <= 1'b1;
    end
  end

  a_obuf_no_overflow: assert property (@(posedge ddr2_clk) disable iff (!sys_rst_n)
    line_push |-> (ob_cnt != OB_FULL || ob_pop));

`ifdef DDR2_OUT_STAT_EN
  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_req_cnt  <= '0;
      stat_line_cnt <= '0;
    end else if (stat_clr) begin
      stat_req_cnt  <= '0;
      stat_line_cnt <= '0;
    end else begin
      if (sf_pop)    stat_req_cnt  <= stat_req_cnt + 32'd1;
      if (line_push) stat_line_cnt <= stat_line_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr2_ctrl_output.sv
// tb/tb_ddr2_ctrl_output.sv - self-checking bench for ddr2_ctrl_output against a line-level model
module tb_ddr2_ctrl_output;

  logic         ddr2_clk = 1'b0;
  logic         sys_rst_n;
  logic [6:0]   rd_ddr2_size;
  logic         rd_ddr2_size_wrreq;
  logic         read_permit;
  logic [31:0]  local_rdata;
  logic         local_rdata_valid;
  logic [127:0] ddr2um_data;
  logic         ddr2um_last;
  logic         ddr2um_valid;
  logic         ddr2um_rdreq;
  logic         rd_err;
`ifdef DDR2_OUT_STAT_EN
  logic         stat_clr;
  logic [31:0]  stat_req_cnt;
  logic [31:0]  stat_line_cnt;
`endif

  ddr2_ctrl_output dut (
    .ddr2_clk           (ddr2_clk),
    .sys_rst_n          (sys_rst_n),
    .rd_ddr2_size       (rd_ddr2_size),
    .rd_ddr2_size_wrreq (rd_ddr2_size_wrreq),
    .read_permit        (read_permit),
    .local_rdata        (local_rdata),
    .local_rdata_valid  (local_rdata_valid),
    .ddr2um_data        (ddr2um_data),
    .ddr2um_last        (ddr2um_last),
    .ddr2um_valid       (ddr2um_valid),
    .ddr2um_rdreq       (ddr2um_rdreq),
    .rd_err             (rd_err)
`ifdef DDR2_OUT_STAT_EN
    ,
    .stat_clr           (stat_clr),
    .stat_req_cnt       (stat_req_cnt),
    .stat_line_cnt      (stat_line_cnt)
`endif
  );

  always #5 ddr2_clk = ~ddr2_clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } line_t;

  int          errors = 0;
  int          checks = 0;
  int          outstanding = 0;
  line_t       exp_q[$];
  logic [31:0] beat_q[$];

  task automatic step();
    @(posedge ddr2_clk);
    #1;
  endtask

  task automatic post(input int size);
    rd_ddr2_size       = 7'(size);
    rd_ddr2_size_wrreq = 1'b1;
    step();
    rd_ddr2_size_wrreq = 1'b0;
    outstanding += (size + 3) / 4;
  endtask

  // Reference: a request of n words becomes ceil(n/4) lines, words packed MSB-first, zero filled.
  task automatic model_req(input int size, input bit rnd, input logic [31:0] base);
    logic [31:0] w[$];
    line_t       l;
    for (int i = 0; i < size; i++) begin
      w.push_back(rnd ? $urandom : base + 32'(i));
      beat_q.push_back(w[i]);
    end
    for (int i = 0; i < size; i += 4) begin
      l.data = '0;
      for (int j = 0; j < 4; j++)
        if (i + j < size) l.data[127 - 32*j -: 32] = w[i + j];
      l.last = (i + 4 >= size);
      exp_q.push_back(l);
    end
  endtask

  task automatic send_beats(input int max_gap);
    while (beat_q.size() > 0) begin
      repeat ($urandom_range(0, max_gap)) step();
      local_rdata       = beat_q.pop_front();
      local_rdata_valid = 1'b1;
      step();
      local_rdata_valid = 1'b0;
    end
  endtask

  task automatic pop_lines(input int n, input string tag);
    line_t e;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!ddr2um_valid && t < 200) begin
        step();
        t++;
      end
      checks++;
      if (!ddr2um_valid) begin
        errors++;
        $display("FAIL %s_timeout: line %0d valid=%b required 1", tag, k, ddr2um_valid);
        return;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_extra: got line %h last=%b, required none", tag, ddr2um_data, ddr2um_last);
      end else begin
        e = exp_q.pop_front();
        if ({ddr2um_data, ddr2um_last} !== {e.data, e.last}) begin
          errors++;
          $display("FAIL %s_line%0d: got %h last=%b, required %h last=%b",
                   tag, k, ddr2um_data, ddr2um_last, e.data, e.last);
        end
      end
      ddr2um_rdreq = 1'b1;
      step();
      ddr2um_rdreq = 1'b0;
      outstanding--;
    end
  endtask

  task automatic test_reset();
    sys_rst_n          = 1'b0;
    rd_ddr2_size       = '0;
    rd_ddr2_size_wrreq = 1'b0;
    local_rdata        = '0;
    local_rdata_valid  = 1'b0;
    ddr2um_rdreq       = 1'b0;
`ifdef DDR2_OUT_STAT_EN
    stat_clr           = 1'b0;
`endif
    repeat (3) step();
    checks++;
    if ({read_permit, ddr2um_valid, ddr2um_last, rd_err, ddr2um_data} !== 132'd0) begin
      errors++;
      $display("FAIL reset_values: permit=%b valid=%b last=%b err=%b data=%h, required all 0",
               read_permit, ddr2um_valid, ddr2um_last, rd_err, ddr2um_data);
    end
    sys_rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({read_permit, ddr2um_valid, rd_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: permit=%b valid=%b err=%b, required 1 0 0",
               read_permit, ddr2um_valid, rd_err);
    end
  endtask

  task automatic test_size8();
    model_req(8, 1'b0, 32'h11);
    post(8);
    for (int i = 0; i < 4; i++) begin
      local_rdata       = beat_q.pop_front();
      local_rdata_valid = 1'b1;
      step();
      if (i == 2) begin
        checks++;
        if (ddr2um_valid !== 1'b0) begin
          errors++;
          $display("FAIL size8_early: valid=%b after 3 beats, required 0", ddr2um_valid);
        end
      end
    end
    local_rdata_valid = 1'b0;
    checks++;
    if (ddr2um_valid !== 1'b1 || ddr2um_data !== 128'h00000011_00000012_00000013_00000014) begin
      errors++;
      $display("FAIL size8_latency: valid=%b data=%h, required 1 00000011000000120000001300000014",
               ddr2um_valid, ddr2um_data);
    end
    send_beats(0);
    pop_lines(2, "size8");
    checks++;
    if (read_permit !== 1'b1 || ddr2um_valid !== 1'b0) begin
      errors++;
      $display("FAIL size8_after: permit=%b valid=%b, required 1 0", read_permit, ddr2um_valid);
    end
  endtask

  task automatic test_size6();
    model_req(6, 1'b0, 32'hA1);
    post(6);
    send_beats(2);
    checks++;
    if ({ddr2um_data, ddr2um_last} !== {128'h000000A1_000000A2_000000A3_000000A4, 1'b0}) begin
      errors++;
      $display("FAIL size6_head: got %h last=%b, required 000000a1000000a2000000a3000000a4 last=0",
               ddr2um_data, ddr2um_last);
    end
    pop_lines(2, "size6");
  endtask

  task automatic test_credit();
    model_req(127, 1'b1, 0);
    post(127);
    checks++;
    if (read_permit !== 1'b1 || read_permit !== ((64 - outstanding) >= 32)) begin
      errors++;
      $display("FAIL credit_first: permit=%b, required 1", read_permit);
    end
    model_req(127, 1'b1, 0);
    post(127);
    checks++;
    if (read_permit !== 1'b0) begin
      errors++;
      $display("FAIL credit_second: permit=%b, required 0", read_permit);
    end
    send_beats(0);
    pop_lines(31, "credit_a");
    checks++;
    if (read_permit !== 1'b0) begin
      errors++;
      $display("FAIL credit_31pops: permit=%b, required 0", read_permit);
    end
    pop_lines(1, "credit_b");
    checks++;
    if (read_permit !== 1'b1) begin
      errors++;
      $display("FAIL credit_32pops: permit=%b, required 1", read_permit);
    end
    pop_lines(32, "credit_c");
    checks++;
    if (ddr2um_valid !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL credit_drained: valid=%b err=%b, required 0 0", ddr2um_valid, rd_err);
    end
  endtask

  task automatic test_back_to_back();
    model_req(4, 1'b1, 0);
    model_req(2, 1'b1, 0);
    post(4);
    post(2);
    send_beats(0);
    pop_lines(2, "b2b");
    checks++;
    if (rd_err !== 1'b0 || ddr2um_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clean: err=%b valid=%b, required 0 0", rd_err, ddr2um_valid);
    end
    local_rdata       = $urandom;
    local_rdata_valid = 1'b1;
    step();
    local_rdata_valid = 1'b0;
    step();
    checks++;
    if (rd_err !== 1'b1 || ddr2um_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_beat: err=%b valid=%b, required 1 0", rd_err, ddr2um_valid);
    end
  endtask

  task automatic test_zero_size();
`ifdef DDR2_OUT_STAT_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
`endif
    model_req(0, 1'b1, 0);
    model_req(4, 1'b1, 0);
    post(0);
    post(4);
    repeat (3) step();
    send_beats(1);
    pop_lines(1, "zero");
    repeat (4) step();
    checks++;
    if (ddr2um_valid !== 1'b0 || read_permit !== 1'b1) begin
      errors++;
      $display("FAIL zero_one_line: valid=%b permit=%b, required 0 1", ddr2um_valid, read_permit);
    end
`ifdef DDR2_OUT_STAT_EN
    checks++;
    if (stat_req_cnt !== 32'd2 || stat_line_cnt !== 32'd1) begin
      errors++;
      $display("FAIL zero_stats: req=%0d lines=%0d, required 2 1", stat_req_cnt, stat_line_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      int got = 0;
      for (int q = 0; q < 3; q++) begin
        int sz = $urandom_range(1, 40);
        model_req(sz, 1'b1, 0);
        post(sz);
      end
      n = exp_q.size();
      fork
        send_beats(2);
        begin
          int t = 0;
          line_t e;
          while (got < n && t < 3000) begin
            if (ddr2um_valid && $urandom_range(0, 1) == 1) begin
              e = exp_q.pop_front();
              checks++;
              if ({ddr2um_data, ddr2um_last} !== {e.data, e.last}) begin
                errors++;
                $display("FAIL random_r%0d_line%0d: got %h last=%b, required %h last=%b",
                         r, got, ddr2um_data, ddr2um_last, e.data, e.last);
              end
              got++;
              outstanding--;
              ddr2um_rdreq = 1'b1;
            end else begin
              ddr2um_rdreq = 1'b0;
            end
            step();
            t++;
          end
          ddr2um_rdreq = 1'b0;
        end
      join
      step();
      checks++;
      if (got !== n || ddr2um_valid !== 1'b0 || read_permit !== 1'b1) begin
        errors++;
        $display("FAIL random_r%0d_end: lines=%0d valid=%b permit=%b, required %0d 0 1",
                 r, got, ddr2um_valid, read_permit, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_size8();
    test_size6();
    test_credit();
    test_random();
    test_back_to_back();
    test_zero_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
